ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage: holds the architectural fetch PC, requests 32-bit words from the instruction cache, and predicts the next PC. It uses a 2-bit-counter branch history table (BHT) and static JAL redirection. Each fetched instruction goes to the decoder as a one-cycle `inst_rdy` pulse with its PC and prediction bit. It stalls when the reorder buffer (ROB), reservation station (RS) or load/store buffer (LSB) cannot accept another entry, and restarts on ROB rollback.

## Interface
- `BHT_LOG`, 8, log2 of BHT entries; index = `pc[BHT_LOG+1:2]`
- `RESET_PC`, 32'h0, fetch PC after reset
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `rdy` in 1: global enable; low freezes every register
- `icache_req` out 1: fetch request, level, held until `icache_rdy`
- `icache_addr` out 32: word address of request (= `pc`)
- `icache_rdy` in 1: `icache_inst` is valid for `icache_addr` this cycle
- `icache_inst` in 32: returned instruction word
- `rob_nxt_full`, `rs_nxt_full`, `lsb_nxt_full` in 1 each: unit cannot accept an issue next cycle
- `rollback` in 1: mispredict or flush
- `rollback_pc` in 32: correct restart PC
- `br_upd` in 1: committed conditional branch
- `br_upd_pc` in 32: PC of that branch
- `br_upd_taken` in 1: its resolved direction
- `inst_rdy` out 1: one-cycle issue pulse to decoder
- `inst` out 32: instruction
- `inst_pc` out 32: its PC
- `inst_pred_jump` out 1: predicted taken

## Operation
- Reset: `pc`=`RESET_PC`, state FETCH, `inst_rdy`=0, `inst`/`inst_pc`=0, `inst_pred_jump`=0, `icache_req`=0, all BHT counters=2'b01 (weakly not-taken).
- `stall` = `rob_nxt_full | rs_nxt_full | lsb_nxt_full`.
- States:
  - FETCH: `icache_req`=1, `icache_addr`=`pc`.
    - On `icache_rdy` & !`stall`: latch word, issue, move `pc`, stay in FETCH.
    - On `icache_rdy` & `stall`: latch word into a hold register, go to HOLD.
  - HOLD: `icache_req`=0. When !`stall`: issue the held word, move `pc`, go to FETCH.
- Issue: `inst_rdy`<=1 with `inst`, `inst_pc`=`pc`, `inst_pred_jump`. `inst_rdy`<=0 on every other active cycle.
- Next-PC prediction, from opcode `inst[6:0]`:
  - JAL 1101111: `pc` + J-imm, pred=1.
  - BR 1100011: if BHT[idx][1] then `pc` + B-imm, pred=1; else `pc`+4, pred=0.
  - All others, JALR included: `pc`+4, pred=0.
- Immediates, 32-bit wrap-around adds:
  - J-imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 0}
  - B-imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 0}
- BHT update on `br_upd`: counter at `br_upd_pc[BHT_LOG+1:2]` saturating +1 if taken, else saturating −1 (limits 0 and 3).
- Rollback has highest priority, any state:
  - `pc`<=`rollback_pc`, state<=FETCH, `inst_rdy`<=0, hold register discarded.
  - `icache_rdy` in the rollback cycle is ignored.
  - A BHT update in the same cycle is still applied.

## Timing
- Cache hit (`icache_rdy` in the cycle `icache_addr` is presented, cycle t): `inst_rdy`=1 at t+1, new `icache_addr` at t+1. Peak throughput is one instruction per cycle.
- Stall is sampled in cycle t. The issue at t+1 is guaranteed acceptable downstream.
- HOLD release: `stall` falls in cycle u → `inst_rdy`=1 at u+1; FETCH resumes at u+1.
- Rollback at cycle r: `icache_addr`=`rollback_pc` at r+1. No `inst_rdy` at r+1 unless the cache hits at r+1, which gives `inst_rdy` at r+2.
- BHT read and write to the same index in one cycle: the prediction uses the old counter; the new value is visible next cycle.
- `rdy`=0: no register changes, including `inst_rdy`. A pending pulse is therefore presented once, on the first cycle `rdy`=1.
- Reset mid-miss: outputs return to reset values immediately (asynchronous); the cache response is ignored.

## Test plan
- Reset, then always-hit cache returning `addi` (0x00100093) at every address → `inst_rdy` every cycle, `inst_pc`=0,4,8,… from cycle 2, `inst_pred_jump`=0.
- JAL 0x0100006F at pc 0x10 → next `icache_addr`=0x20, `inst_pred_jump`=1.
- BEQ 0x00000463 (B-imm +8) at pc 0x40:
  - Reset BHT → next PC 0x44, pred 0.
  - After two `br_upd` taken with `br_upd_pc`=0x40 → next PC 0x48, pred 1.
  - Four not-taken updates → counter saturates at 0.
- `rob_nxt_full`=1 while a hit arrives at pc 0x8 → enter HOLD, `icache_req`=0, no `inst_rdy`. Deassert 3 cycles later → single `inst_rdy` with `inst_pc`=0x8, then fetch of 0xC.
- `rollback`=1, `rollback_pc`=0x100, coincident with `icache_rdy` → no `inst_rdy` next cycle, `icache_addr`=0x100, stale word never issued. Repeat while in HOLD → held word dropped.
- `rdy` low during an `inst_rdy` pulse for 2 cycles → `inst`, `inst_pc` and `pc` unchanged; exactly one issue after `rdy` rises.

Source files
------------

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_if
//  Description : Bundle of every non-clock/reset signal of the instruction
//                fetch stage: global enable, instruction-cache request and
//                response, back-pressure from ROB/RS/LSB, rollback, committed
//                branch updates and the issue port toward the decoder.
//  Modports    : master - the fetch stage (drives request and issue outputs)
//                slave  - the environment (cache, backend, decoder)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if;
   logic        rdy;            // global enable, low freezes the stage
   logic        icache_req;     // fetch request, level
   logic [31:0] icache_addr;    // address of the word being requested
   logic        icache_rdy;     // icache_inst valid for icache_addr
   logic [31:0] icache_inst;    // returned instruction word
   logic        rob_nxt_full;   // ROB cannot take an issue next cycle
   logic        rs_nxt_full;    // RS cannot take an issue next cycle
   logic        lsb_nxt_full;   // LSB cannot take an issue next cycle
   logic        rollback;       // mispredict / flush
   logic [31:0] rollback_pc;    // restart PC
   logic        br_upd;         // committed conditional branch
   logic [31:0] br_upd_pc;      // PC of that branch
   logic        br_upd_taken;   // resolved direction
   logic        inst_rdy;       // one-cycle issue pulse
   logic [31:0] inst;           // issued instruction
   logic [31:0] inst_pc;        // PC of issued instruction
   logic        inst_pred_jump; // issued instruction predicted taken

   modport master (
      input  rdy, icache_rdy, icache_inst,
      input  rob_nxt_full, rs_nxt_full, lsb_nxt_full,
      input  rollback, rollback_pc,
      input  br_upd, br_upd_pc, br_upd_taken,
      output icache_req, icache_addr,
      output inst_rdy, inst, inst_pc, inst_pred_jump
   );

   modport slave (
      output rdy, icache_rdy, icache_inst,
      output rob_nxt_full, rs_nxt_full, lsb_nxt_full,
      output rollback, rollback_pc,
      output br_upd, br_upd_pc, br_upd_taken,
      input  icache_req, icache_addr,
      input  inst_rdy, inst, inst_pc, inst_pred_jump
   );
endinterface
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch stage. Holds the fetch PC, requests words
//                from the instruction cache, issues each word to the decoder
//                as a one-cycle pulse and predicts the next PC using static
//                JAL redirection and a table of 2-bit saturating counters for
//                conditional branches.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - ifetch_if.master (cache, backend, decoder signals)
//  Parameters  : BHT_LOG  - log2 of branch history table entries
//                RESET_PC - fetch PC after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch #(
   parameter int          BHT_LOG  = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic      clk,
   input  logic      rst,
   ifetch_if.master  bus
);

   localparam int         BHT_N     = 1 << BHT_LOG;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] hold_q;
   logic        req_q;
   logic        inst_rdy_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        pred_q;
   logic [1:0]  bht_q [BHT_N];

   logic               stall_d;
   logic [31:0]        word_d;
   logic [31:0]        jimm_d;
   logic [31:0]        bimm_d;
   logic [31:0]        npc_d;
   logic               pred_d;
   logic [BHT_LOG-1:0] rd_idx_d;
   logic [BHT_LOG-1:0] wr_idx_d;
   logic               unused_d;

   assign stall_d  = bus.rob_nxt_full | bus.rs_nxt_full | bus.lsb_nxt_full;
   // The word to issue comes straight from the cache in FETCH and from the
   // hold register when a stalled word is released.
   assign word_d   = (state_q == S_HOLD) ? hold_q : bus.icache_inst;
   assign jimm_d   = {{12{word_d[31]}}, word_d[19:12], word_d[20], word_d[30:21], 1'b0};
   assign bimm_d   = {{20{word_d[31]}}, word_d[7], word_d[30:25], word_d[11:8], 1'b0};
   assign rd_idx_d = pc_q[BHT_LOG+1:2];
   assign wr_idx_d = bus.br_upd_pc[BHT_LOG+1:2];
   assign unused_d = ^{bus.br_upd_pc[31:BHT_LOG+2], bus.br_upd_pc[1:0]};

   // Next-PC prediction. The counter is read before any same-cycle update
   // lands, so a coincident update only affects later predictions.
   always_comb begin
      npc_d  = pc_q + 32'd4;
      pred_d = 1'b0;
      if (word_d[6:0] == OP_JAL) begin
         npc_d  = pc_q + jimm_d;
         pred_d = 1'b1;
      end else if (word_d[6:0] == OP_BRANCH && bht_q[rd_idx_d][1]) begin
         npc_d  = pc_q + bimm_d;
         pred_d = 1'b1;
      end
   end

   // Fetch control. The request is registered, so it first rises on the
   // cycle after reset; a response is only accepted while it is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         hold_q     <= 32'h0;
         req_q      <= 1'b0;
         inst_rdy_q <= 1'b0;
         inst_q     <= 32'h0;
         inst_pc_q  <= 32'h0;
         pred_q     <= 1'b0;
      end else if (bus.rdy) begin
         inst_rdy_q <= 1'b0;
         if (bus.rollback) begin
            // Any response in this cycle and any held word are dropped.
            pc_q    <= bus.rollback_pc;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
         end else if (state_q == S_HOLD) begin
            if (!stall_d) begin
               inst_rdy_q <= 1'b1;
               inst_q     <= word_d;
               inst_pc_q  <= pc_q;
               pred_q     <= pred_d;
               pc_q       <= npc_d;
               state_q    <= S_FETCH;
               req_q      <= 1'b1;
            end
         end else if (req_q && bus.icache_rdy) begin
            if (stall_d) begin
               hold_q  <= bus.icache_inst;
               state_q <= S_HOLD;
               req_q   <= 1'b0;
            end else begin
               inst_rdy_q <= 1'b1;
               inst_q     <= word_d;
               inst_pc_q  <= pc_q;
               pred_q     <= pred_d;
               pc_q       <= npc_d;
            end
         end else begin
            req_q <= 1'b1;
         end
      end
   end

   // Branch history table: 2-bit saturating counters, reset weakly not-taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < BHT_N; k++) begin
            bht_q[k] <= 2'b01;
         end
      end else if (bus.rdy && bus.br_upd) begin
         if (bus.br_upd_taken) begin
            if (bht_q[wr_idx_d] != 2'b11) bht_q[wr_idx_d] <= bht_q[wr_idx_d] + 2'd1;
         end else begin
            if (bht_q[wr_idx_d] != 2'b00) bht_q[wr_idx_d] <= bht_q[wr_idx_d] - 2'd1;
         end
      end
   end

   assign bus.icache_req     = req_q;
   assign bus.icache_addr    = pc_q;
   assign bus.inst_rdy       = inst_rdy_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.inst_pred_jump = pred_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch
//  Description : Self-checking bench for ifetch. Directed scenarios followed
//                by randomized traffic, compared every cycle against a
//                transaction-level reference model of the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_if ifc ();

   ifetch #(.BHT_LOG(8), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Instruction memory seen by the cache; unknown addresses read as addi,
   // or as a random instruction mix once rand_mem is set.
   logic [31:0] mem [logic [31:0]];
   bit          rand_mem = 1'b0;

   // Reference model state
   logic [31:0] m_pc, m_held, m_inst, m_inst_pc;
   bit          m_holding, m_req, m_irdy, m_pred;
   int          bht [256];

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      logic [31:0] w;
      if (mem.exists(a)) return mem[a];
      if (!rand_mem) return 32'h00100093;
      case ($urandom_range(0, 4))
         0:       w = 32'h00100093;
         1:       w = ($urandom & ~32'h7F) | 32'h6F;
         2:       w = ($urandom & ~32'h7F) | 32'h63;
         3:       w = ($urandom & ~32'h7F) | 32'h67;
         default: w = $urandom;
      endcase
      mem[a] = w;
      return w;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_held = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0;
      m_holding = 0; m_req = 0; m_irdy = 0; m_pred = 0;
      foreach (bht[k]) bht[k] = 1;
   endtask

   // Issue a word at the model PC and move the PC to its predicted successor.
   task automatic model_issue(input logic [31:0] w);
      int imm;
      imm = 4;
      m_pred = 0;
      if (w[6:0] == 7'b1101111) begin
         imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
               - (w[31] ? (1 << 20) : 0);
         m_pred = 1;
      end else if (w[6:0] == 7'b1100011 && bht[m_pc[9:2]] >= 2) begin
         imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
               - (w[31] ? 4096 : 0);
         m_pred = 1;
      end
      m_irdy    = 1;
      m_inst    = w;
      m_inst_pc = m_pc;
      m_pc      = m_pc + 32'(imm);
   endtask

   task automatic model_step(input bit h, input logic [31:0] w, input bit st,
                             input bit rb, input logic [31:0] rbpc,
                             input bit upd, input logic [31:0] upc,
                             input bit utk, input bit en);
      if (!en) return;
      m_irdy = 0;
      if (rb) begin
         m_pc = rbpc; m_holding = 0; m_req = 1;
      end else if (m_holding) begin
         if (!st) begin
            model_issue(m_held);
            m_holding = 0; m_req = 1;
         end
      end else if (m_req && h) begin
         if (st) begin
            m_held = w; m_holding = 1; m_req = 0;
         end else begin
            model_issue(w);
         end
      end else begin
         m_req = 1;
      end
      if (upd) begin
         if (utk) bht[upc[9:2]] = (bht[upc[9:2]] >= 3) ? 3 : bht[upc[9:2]] + 1;
         else     bht[upc[9:2]] = (bht[upc[9:2]] <= 0) ? 0 : bht[upc[9:2]] - 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("inst_rdy",    32'(ifc.inst_rdy),       32'(m_irdy));
      chk("inst",        ifc.inst,                m_inst);
      chk("inst_pc",     ifc.inst_pc,             m_inst_pc);
      chk("pred",        32'(ifc.inst_pred_jump), 32'(m_pred));
      chk("icache_req",  32'(ifc.icache_req),     32'(m_req));
      chk("icache_addr", ifc.icache_addr,         m_pc);
   endtask

   // One clock cycle: drive inputs (called just after an edge), advance the
   // model at the next edge, then compare.
   task automatic cyc(input bit hit, input bit st, input bit rb,
                      input logic [31:0] rbpc, input bit upd,
                      input logic [31:0] upc, input bit utk, input bit en);
      bit          h;
      logic [31:0] w;
      int          u;
      h = hit & ifc.icache_req;
      w = h ? fetch_word(ifc.icache_addr) : $urandom;
      u = $urandom_range(0, 2);
      ifc.rdy          = en;
      ifc.icache_rdy   = h;
      ifc.icache_inst  = w;
      ifc.rob_nxt_full = st && (u == 0);
      ifc.rs_nxt_full  = st && (u == 1);
      ifc.lsb_nxt_full = st && (u == 2);
      ifc.rollback     = rb;
      ifc.rollback_pc  = rbpc;
      ifc.br_upd       = upd;
      ifc.br_upd_pc    = upc;
      ifc.br_upd_taken = utk;
      @(posedge clk);
      model_step(h, w, st, rb, rbpc, upd, upc, utk, en);
      #1;
      check_all();
   endtask

   task automatic hit_c();                      cyc(1, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic idle_c();                     cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic rb_c(input logic [31:0] p);   cyc(0, 0, 1, p, 0, 0, 0, 1); endtask
   task automatic upd_c(input bit t);           cyc(0, 0, 0, 0, 1, 32'h40, t, 1); endtask

   initial begin
      ifc.rdy = 1; ifc.icache_rdy = 0; ifc.icache_inst = 0;
      ifc.rob_nxt_full = 0; ifc.rs_nxt_full = 0; ifc.lsb_nxt_full = 0;
      ifc.rollback = 0; ifc.rollback_pc = 0;
      ifc.br_upd = 0; ifc.br_upd_pc = 0; ifc.br_upd_taken = 0;
      mem[32'h10]  = 32'h0100006F;   // jal +16
      mem[32'h40]  = 32'h00000463;   // beq +8
      mem[32'h100] = 32'hDEADB0B3;
      model_reset();
      #1 check_all();
      @(posedge clk); #1 rst = 1'b0;

      // addi stream from reset, then JAL at 0x10 redirects to 0x20
      for (int k = 0; k < 10 && !(m_irdy && m_inst_pc == 32'h10); k++) hit_c();
      chk("jal_target", ifc.icache_addr, 32'h20);
      chk("jal_pred", 32'(ifc.inst_pred_jump), 32'h1);

      // BEQ at 0x40 with the reset counter: falls through
      rb_c(32'h40); hit_c();
      chk("beq_nt_addr", ifc.icache_addr, 32'h44);
      // two taken updates make it predicted taken
      upd_c(1); upd_c(1); rb_c(32'h40); hit_c();
      chk("beq_t_addr", ifc.icache_addr, 32'h48);
      chk("beq_t_pred", 32'(ifc.inst_pred_jump), 32'h1);
      // four not-taken updates saturate at 0; one taken leaves it not-taken
      for (int k = 0; k < 4; k++) upd_c(0);
      rb_c(32'h40); hit_c();
      chk("beq_sat_addr", ifc.icache_addr, 32'h44);
      upd_c(1); rb_c(32'h40); hit_c();
      chk("beq_sat1_addr", ifc.icache_addr, 32'h44);

      // stall at 0x8: hold for three cycles, then release
      rb_c(32'h8);
      cyc(1, 1, 0, 0, 0, 0, 0, 1);
      chk("hold_req", 32'(ifc.icache_req), 32'h0);
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 0, 1);
      idle_c();
      chk("release_pc", ifc.inst_pc, 32'h8);
      chk("release_addr", ifc.icache_addr, 32'hC);
      hit_c();

      // rollback coincident with a hit, then rollback while holding
      cyc(1, 0, 1, 32'h100, 0, 0, 0, 1);
      chk("rb_addr", ifc.icache_addr, 32'h100);
      cyc(1, 1, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 32'h200, 0, 0, 0, 1);
      chk("rb_hold_irdy", 32'(ifc.inst_rdy), 32'h0);
      hit_c();
      chk("rb_hold_pc", ifc.inst_pc, 32'h200);

      // rdy low across an issue pulse
      hit_c();
      cyc(1, 0, 1, 32'h300, 1, 32'h40, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      idle_c();

      // asynchronous reset in the middle of a miss
      idle_c(); idle_c();
      #3 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(posedge clk); #1 rst = 1'b0;

      // randomized traffic
      rand_mem = 1'b1;
      mem.delete();
      for (int k = 0; k < 800; k++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0, {22'h0, 8'($urandom), 2'b00},
             $urandom_range(0, 2) == 0, {24'h0, 6'($urandom), 2'b00},
             1'($urandom), $urandom_range(0, 9) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
